// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction store with byte-stream boot loader and fetch read port
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  addra,
    output logic [INSTR_W-1:0] douta,
    input  logic               ld_start,
    input  logic [ADDR_W-1:0]  ld_len,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]    cnt;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         csum;
    logic [7:0]         hi;

    logic xfer;
    logic start_ld;
    logic cap_hi;
    logic wr_en;
    logic csum_good;
    logic csum_bad;

    assign byte_ready = (state != IDLE);
    assign busy       = (state != IDLE);
    assign xfer       = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ld  = 1'b0;
        cap_hi    = 1'b0;
        wr_en     = 1'b0;
        csum_good = 1'b0;
        csum_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    start_ld  = 1'b1;
                    state_nxt = HI;
                end
            end
            HI: begin
                if (xfer) begin
                    cap_hi    = 1'b1;
                    state_nxt = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    wr_en     = 1'b1;
                    state_nxt = (cnt == {{ADDR_W{1'b0}}, 1'b1}) ? CSUM : HI;
                end
            end
            CSUM: begin
                if (xfer) begin
                    csum_good = (byte_data == csum);
                    csum_bad  = (byte_data != csum);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Loader datapath; a zero length selects a full-depth load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            wr_addr <= '0;
            csum    <= '0;
            hi      <= '0;
            err     <= 1'b0;
            cpu_rst <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= csum_good;
            if (start_ld) begin
                cnt     <= (ld_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, ld_len};
                wr_addr <= '0;
                csum    <= '0;
                err     <= 1'b0;
                cpu_rst <= 1'b1;
            end
            if (cap_hi) begin
                hi   <= byte_data;
                csum <= csum ^ byte_data;
            end
            if (wr_en) begin
                csum    <= csum ^ byte_data;
                wr_addr <= wr_addr + 1'b1;
                cnt     <= cnt - 1'b1;
            end
            if (csum_good) begin
                cpu_rst <= 1'b0;
            end
            if (csum_bad) begin
                err <= 1'b1;
            end
        end
    end

    // Store itself is not reset so a reset mid-load keeps already written words
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {hi, byte_data};
        end
    end

    // Read-before-write: a same-cycle write to addra returns the old word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            douta <= '0;
        end else begin
            douta <= mem[addra];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addra = '0;
    logic [15:0] douta;
    logic        ld_start = 1'b0;
    logic [7:0]  ld_len = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    imem_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .addra      (addra),
        .douta      (douta),
        .ld_start   (ld_start),
        .ld_len     (ld_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [7:0] len);
        ld_len   = len;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // gap cycles of byte_valid=0 with junk data precede each byte
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent = 0;
        for (int g = 0; g < gap; g++) begin
            byte_valid = 1'b0;
            byte_data  = 8'hEE;
            tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 16 && !sent; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                sent = 1;
            end
        end
        byte_valid = 1'b0;
        if (!sent) check("byte_timeout", 0, 1);
    endtask

    task automatic read_word(input logic [7:0] a, input logic [15:0] exp, input string tag);
        addra = a;
        tick();
        check(tag, douta, exp);
    endtask

    task automatic good_stream(input logic [7:0] last, input int gap);
        send_byte(8'h12, gap);
        send_byte(8'h34, gap);
        send_byte(8'hAB, gap);
        send_byte(8'hCD, gap);
        send_byte(last, gap);
    endtask

    initial begin
        int d0;
        // reset then idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_douta", douta, 16'h0000);
        check("rst_done", done, 0);

        // good 2-word load, checksum 12^34^AB^CD = 40
        start_load(8'd2);
        check("good_busy", busy, 1);
        d0 = done_cnt;
        good_stream(8'h40, 0);
        check("good_done", done, 1);
        check("good_cpu_rst", cpu_rst, 0);
        check("good_busy_end", busy, 0);
        tick();
        check("good_done_once", done_cnt - d0, 1);
        read_word(8'h00, 16'h1234, "good_mem0");
        read_word(8'h01, 16'hABCD, "good_mem1");

        // bad checksum then recovery
        start_load(8'd2);
        check("bad_cpu_rst_reassert", cpu_rst, 1);
        d0 = done_cnt;
        good_stream(8'h41, 0);
        tick();
        check("bad_done", done_cnt - d0, 0);
        check("bad_err", err, 1);
        check("bad_cpu_rst", cpu_rst, 1);
        check("bad_busy", busy, 0);
        start_load(8'd2);
        check("recov_err_clr", err, 0);
        good_stream(8'h40, 0);
        check("recov_cpu_rst", cpu_rst, 0);
        check("recov_err", err, 0);

        // backpressure: two idle cycles before every byte
        start_load(8'd2);
        d0 = done_cnt;
        send_byte(8'h12, 2);
        byte_valid = 1'b0;
        tick();
        check("bp_stall_busy", busy, 1);
        check("bp_stall_ready", byte_ready, 1);
        send_byte(8'h34, 1);
        send_byte(8'hAB, 2);
        send_byte(8'hCD, 2);
        send_byte(8'h40, 2);
        tick();
        check("bp_done", done_cnt - d0, 1);
        check("bp_err", err, 0);
        read_word(8'h00, 16'h1234, "bp_mem0");
        read_word(8'h01, 16'hABCD, "bp_mem1");

        // full depth: word i = {i, ~i}, XOR of all bytes is 0
        start_load(8'd0);
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 0);
            send_byte(~8'(i), 0);
        end
        check("full_in_csum", byte_ready, 1);
        send_byte(8'h00, 0);
        check("full_wr_addr_wrap", dut.wr_addr, 0);
        tick();
        check("full_done", done_cnt - d0, 1);
        check("full_cpu_rst", cpu_rst, 0);
        read_word(8'hFF, 16'hFF00, "full_memFF");
        read_word(8'h00, 16'h00FF, "full_mem00");
        read_word(8'h01, 16'h01FE, "full_mem01");

        // ld_start mid-load is ignored
        start_load(8'd2);
        d0 = done_cnt;
        send_byte(8'h12, 0);
        ld_start = 1'b1;
        ld_len   = 8'd5;
        send_byte(8'h34, 0);
        ld_start = 1'b0;
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'h40, 0);
        tick();
        check("ign_done", done_cnt - d0, 1);
        check("ign_busy", busy, 0);

        // reset after 3 bytes; word 0 written with same-cycle read of old data
        addra = 8'h00;
        start_load(8'd2);
        d0 = done_cnt;
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        check("rw_old_data", douta, 16'h1234);
        send_byte(8'h77, 0);
        check("rw_new_data", douta, 16'h5566);
        rst = 1'b0;
        #1;
        check("abort_ready", byte_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_cpu_rst", cpu_rst, 1);
        check("abort_douta", douta, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_cpu_rst_hold", cpu_rst, 1);
        read_word(8'h00, 16'h5566, "abort_partial_word");
        read_word(8'h01, 16'hABCD, "abort_mem1");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
